// File: rtl/plru_ctrl_if.sv
// Request/response bundle between the cache control FSM and plru_ctrl.
// The master drives requests; the slave returns victim and PLRU word.
interface plru_ctrl_if #(
    parameter int IDX_W = 3
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [IDX_W-1:0] req_index;
    logic [1:0]       req_way;
    logic             rsp_valid;
    logic [1:0]       rsp_victim;
    logic [2:0]       rsp_plru;

    modport master (
        output req_valid, req_op, req_index, req_way,
        input  req_ready, rsp_valid, rsp_victim, rsp_plru
    );

    modport slave (
        input  req_valid, req_op, req_index, req_way,
        output req_ready, rsp_valid, rsp_victim, rsp_plru
    );
endinterface

// File: rtl/plru_ctrl.sv
// 4-way tree pseudo-LRU sequencer: per-set RMW pipeline with same-set forwarding.
// Optional counters enabled by defining PLRU_CTRL_STATS_EN.
module plru_ctrl #(
    parameter  int NUM_SETS = 8,
    localparam int IDX_W    = $clog2(NUM_SETS)
) (
    input  logic        clk,
    input  logic        rst,
    plru_ctrl_if.slave  bus
`ifdef PLRU_CTRL_STATS_EN
    ,
    output logic [31:0] stat_touch,
    output logic [31:0] stat_alloc,
    output logic [31:0] stat_fwd
`endif
);
    typedef enum logic {INIT, RUN} state_t;

    localparam logic [1:0] OP_TOUCH = 2'b00;
    localparam logic [1:0] OP_ALLOC = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SETS - 1);

    state_t           state;
    logic [IDX_W-1:0] cnt;
    logic [2:0]       mem [NUM_SETS];

    logic             ready_q;
    logic             rsp_valid_q;
    logic [1:0]       rsp_victim_q;
    logic [2:0]       rsp_plru_q;

    logic             s1_valid;
    logic [1:0]       s1_op;
    logic [1:0]       s1_way;
    logic [IDX_W-1:0] s1_idx;
    logic [2:0]       s1_word;
    logic [1:0]       s1_vic;
    logic [2:0]       s1_new;

    logic             accept;
    logic             fwd;

    function automatic logic [2:0] upd(input logic [2:0] p,
                                       input logic [1:0] w);
        logic [2:0] r;
        unique case (w)
            2'd0:    r = {2'b11, p[0]};
            2'd1:    r = {2'b10, p[0]};
            2'd2:    r = {1'b0, p[1], 1'b1};
            default: r = {1'b0, p[1], 1'b0};
        endcase
        return r;
    endfunction

    function automatic logic [1:0] victim(input logic [2:0] p);
        return p[2] ? (p[0] ? 2'd3 : 2'd2) : (p[1] ? 2'd1 : 2'd0);
    endfunction

    assign bus.req_ready  = ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_victim = rsp_victim_q;
    assign bus.rsp_plru   = rsp_plru_q;

    assign accept = bus.req_valid && ready_q;
    // S1 writes the array on the same edge S0 reads it, so bypass the stale copy.
    assign fwd    = accept && s1_valid && (s1_idx == bus.req_index);

    always_comb begin
        s1_vic = victim(s1_word);
        s1_new = s1_word;
        unique case (s1_op)
            OP_TOUCH: s1_new = upd(s1_word, s1_way);
            OP_ALLOC: s1_new = upd(s1_word, s1_vic);
            OP_CLEAR: s1_new = 3'b000;
            default:  s1_new = s1_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= INIT;
            cnt          <= '0;
            ready_q      <= 1'b0;
            s1_valid     <= 1'b0;
            s1_op        <= 2'b00;
            s1_way       <= 2'b00;
            s1_idx       <= '0;
            s1_word      <= 3'b000;
            rsp_valid_q  <= 1'b0;
            rsp_victim_q <= 2'b00;
            rsp_plru_q   <= 3'b000;
        end else begin
            rsp_valid_q <= s1_valid;
            if (s1_valid) begin
                rsp_victim_q <= s1_vic;
                rsp_plru_q   <= s1_new;
            end
            s1_valid <= accept;
            if (accept) begin
                s1_op   <= bus.req_op;
                s1_way  <= bus.req_way;
                s1_idx  <= bus.req_index;
                s1_word <= fwd ? s1_new : mem[bus.req_index];
            end
            unique case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: ready_q <= 1'b1;
            endcase
        end
    end

    // The array itself is never reset; INIT sweeps it clean instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT)
                mem[cnt] <= 3'b000;
            else if (s1_valid)
                mem[s1_idx] <= s1_new;
        end
    end

`ifdef PLRU_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_touch <= '0;
            stat_alloc <= '0;
            stat_fwd   <= '0;
        end else begin
            if (s1_valid && s1_op == OP_TOUCH && stat_touch != '1)
                stat_touch <= stat_touch + 1'b1;
            if (s1_valid && s1_op == OP_ALLOC && stat_alloc != '1)
                stat_alloc <= stat_alloc + 1'b1;
            if (fwd && stat_fwd != '1)
                stat_fwd <= stat_fwd + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_plru_ctrl.sv
// Randomized bench for plru_ctrl against a serial per-set PLRU model.
// Build with PLRU_CTRL_STATS_EN to also check the touch/alloc counters.
module tb_plru_ctrl;
    localparam int NSETS = 8;
    localparam int IW    = 3;

    typedef struct {
        int         due;
        int         op;
        logic [1:0] vic;
        logic [2:0] plru;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    plru_ctrl_if #(.IDX_W(IW)) bus ();

`ifdef PLRU_CTRL_STATS_EN
    logic [31:0] stat_touch, stat_alloc, stat_fwd;
    int          m_touch, m_alloc;
`endif

    plru_ctrl #(.NUM_SETS(NSETS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
`ifdef PLRU_CTRL_STATS_EN
        ,
        .stat_touch (stat_touch),
        .stat_alloc (stat_alloc),
        .stat_fwd   (stat_fwd)
`endif
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         ncnt     = 0;
    int         rst_neg  = 0;
    bit         armed    = 0;
    logic [2:0] model [NSETS];
    exp_t       q [$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at step %0d: got %0h, want %0h",
                     tag, ncnt, obs, exp);
        end
    endtask

    // Tree view: top bit says which half is older; lower bits pick within it.
    function automatic logic [1:0] m_victim(input logic [2:0] p);
        int half = p[2];
        int leaf = half ? p[0] : p[1];
        return 2'(2 * half + leaf);
    endfunction

    function automatic logic [2:0] m_use(input logic [2:0] p, input int w);
        logic [2:0] r = p;
        r[2] = (w < 2);
        if (w < 2) r[1] = (w == 0);
        else       r[0] = (w == 2);
        return r;
    endfunction

    task automatic check_outputs();
        bit ready_exp = (ncnt >= rst_neg + 9);
        check("req_ready", 32'(bus.req_ready), 32'(ready_exp));
        if (ncnt == rst_neg + 1) begin
            check("rst_victim", 32'(bus.rsp_victim), 0);
            check("rst_plru", 32'(bus.rsp_plru), 0);
        end
        if (q.size() > 0 && q[0].due == ncnt) begin
            exp_t e = q.pop_front();
            check("rsp_valid", 32'(bus.rsp_valid), 1);
            check("rsp_victim", 32'(bus.rsp_victim), 32'(e.vic));
            check("rsp_plru", 32'(bus.rsp_plru), 32'(e.plru));
`ifdef PLRU_CTRL_STATS_EN
            if (e.op == 0) m_touch++;
            if (e.op == 1) m_alloc++;
`endif
        end else begin
            check("rsp_idle", 32'(bus.rsp_valid), 0);
        end
    endtask

    task automatic step(input bit r, input bit v, input int op,
                        input int idx, input int way);
        @(negedge clk);
        ncnt++;
        if (armed) check_outputs();
        rst           = r;
        bus.req_valid = v;
        bus.req_op    = 2'(op);
        bus.req_index = IW'(idx);
        bus.req_way   = 2'(way);
        if (r) begin
            q.delete();
            rst_neg = ncnt;
            for (int i = 0; i < NSETS; i++) model[i] = 3'b000;
`ifdef PLRU_CTRL_STATS_EN
            m_touch = 0;
            m_alloc = 0;
`endif
        end else if (v && ncnt >= rst_neg + 9) begin
            exp_t       e;
            logic [2:0] pre = model[idx];
            e.due = ncnt + 2;
            e.op  = op;
            e.vic = m_victim(pre);
            case (op)
                0:       e.plru = m_use(pre, way);
                1:       e.plru = m_use(pre, int'(e.vic));
                2:       e.plru = 3'b000;
                default: e.plru = pre;
            endcase
            model[idx] = e.plru;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_index = '0;
        bus.req_way   = 2'b00;
        step(1, 0, 0, 0, 0);
        armed = 1;
        idle(9);
        // READ fresh set
        step(0, 1, 3, 6, 0);
        idle(2);
        // ALLOC x4 on set 5 back-to-back
        for (int i = 0; i < 4; i++) step(0, 1, 1, 5, 0);
        idle(2);
        // TOUCH/READ set 2
        step(0, 1, 0, 2, 3);
        step(0, 1, 3, 2, 0);
        step(0, 1, 0, 2, 0);
        step(0, 1, 3, 2, 0);
        // interleaved ALLOC set 1/4/1
        step(0, 1, 1, 1, 0);
        step(0, 1, 1, 4, 0);
        step(0, 1, 1, 1, 0);
        // TOUCH way 1, CLEAR, READ set 3
        step(0, 1, 0, 3, 1);
        step(0, 1, 2, 3, 0);
        step(0, 1, 3, 3, 0);
        idle(2);
        // reset the cycle after an accept
        step(0, 1, 0, 7, 0);
        step(1, 0, 0, 0, 0);
        idle(9);
        step(0, 1, 3, 2, 0);
        step(0, 1, 3, 7, 0);
        step(0, 1, 3, 3, 0);
        idle(2);
        // reset part-way through INIT
        step(1, 0, 0, 0, 0);
        idle(4);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 2);
        idle(8);
        // randomized traffic on a few sets to stress forwarding
        for (int i = 0; i < 400; i++) begin
            bit r = ($urandom_range(0, 149) == 0);
            bit v = ($urandom_range(0, 9) < 8);
            step(r, v, $urandom_range(0, 3), $urandom_range(0, 2) == 0 ?
                 $urandom_range(0, NSETS - 1) : $urandom_range(0, 1),
                 $urandom_range(0, 3));
        end
        idle(3);
        check("drained", 32'(q.size()), 0);
`ifdef PLRU_CTRL_STATS_EN
        check("stat_touch", stat_touch, 32'(m_touch));
        check("stat_alloc", stat_alloc, 32'(m_alloc));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
